// File: rtl/me_frame_scheduler_if.sv
// Block-controller and result-channel signals between the frame scheduler
// and its block controller / result consumer.
interface me_frame_scheduler_if #(
  parameter int MB_BITS = 7,
  parameter int SAD_W   = 16
);
  logic               ctrl_go;
  logic [1:0]         ctrl_r;
  logic               ctrl_done;
  logic               sad_valid;
  logic [SAD_W-1:0]   sad_in;
  logic [7:0]         mv_x_in;
  logic [7:0]         mv_y_in;
  logic               res_valid;
  logic               res_ready;
  logic [SAD_W-1:0]   res_sad;
  logic [7:0]         res_mv_x;
  logic [7:0]         res_mv_y;
  logic [MB_BITS-1:0] res_mb_x;
  logic [MB_BITS-1:0] res_mb_y;
  logic               res_err;

  modport master (
    output ctrl_go, ctrl_r, res_valid, res_sad, res_mv_x, res_mv_y,
           res_mb_x, res_mb_y, res_err,
    input  ctrl_done, sad_valid, sad_in, mv_x_in, mv_y_in, res_ready
  );

  modport slave (
    input  ctrl_go, ctrl_r, res_valid, res_sad, res_mv_x, res_mv_y,
           res_mb_x, res_mb_y, res_err,
    output ctrl_done, sad_valid, sad_in, mv_x_in, mv_y_in, res_ready
  );
endinterface

// File: rtl/me_frame_scheduler.sv
// Motion-estimation frame scheduler: walks the frame macroblock by macroblock,
// launches the block controller, keeps the best SAD candidate and emits results.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for frame_start, config may be re-latched
// S_LAUNCH | one-cycle ctrl_go, best-candidate and timeout reset
// S_WAIT   | collecting SAD candidates until ctrl_done or timeout
// S_EMIT   | result presented, held until res_ready
// S_NEXT   | advance raster position or finish the frame
// S_FDONE  | one-cycle frame_done pulse
module me_frame_scheduler #(
  parameter int MB_BITS = 7,
  parameter int SAD_W   = 16,
  parameter int TIMEOUT = 8192
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [MB_BITS-1:0] frame_w_mb,
  input  logic [MB_BITS-1:0] frame_h_mb,
  input  logic [1:0]         r_cfg,
  output logic [MB_BITS-1:0] mb_x,
  output logic [MB_BITS-1:0] mb_y,
  output logic               busy,
  output logic               frame_done,
  me_frame_scheduler_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_EMIT,
    S_NEXT,
    S_FDONE
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [MB_BITS-1:0] w_lat;
  logic [MB_BITS-1:0] h_lat;
  logic [1:0]         r_lat;
  logic [SAD_W-1:0]   best_sad;
  logic [7:0]         best_mv_x;
  logic [7:0]         best_mv_y;
  logic               err_r;
  logic [TO_W-1:0]    to_cnt;

  logic               dim_zero;
  logic               x_last;
  logic               y_last;
  logic               to_last;
  logic               sad_better;

  assign dim_zero   = (frame_w_mb == '0) || (frame_h_mb == '0);
  assign x_last     = (mb_x == w_lat - MB_BITS'(1));
  assign y_last     = (mb_y == h_lat - MB_BITS'(1));
  assign to_last    = (to_cnt == TO_W'(TIMEOUT - 1));
  // strict compare: equal SADs keep the earlier candidate
  assign sad_better = bus.sad_valid && (bus.sad_in < best_sad);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.ctrl_go   = 1'b0;
    bus.res_valid = 1'b0;
    frame_done    = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_start) begin
          state_nxt = dim_zero ? S_FDONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        bus.ctrl_go = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.ctrl_done || to_last) begin
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        state_nxt = (x_last && y_last) ? S_FDONE : S_LAUNCH;
      end
      S_FDONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_lat     <= '0;
      h_lat     <= '0;
      r_lat     <= '0;
      mb_x      <= '0;
      mb_y      <= '0;
      best_sad  <= '1;
      best_mv_x <= '0;
      best_mv_y <= '0;
      err_r     <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            w_lat <= frame_w_mb;
            h_lat <= frame_h_mb;
            r_lat <= r_cfg;
            mb_x  <= '0;
            mb_y  <= '0;
          end
        end
        S_LAUNCH: begin
          best_sad  <= '1;
          best_mv_x <= '0;
          best_mv_y <= '0;
          err_r     <= 1'b0;
          to_cnt    <= '0;
        end
        S_WAIT: begin
          if (sad_better) begin
            best_sad  <= bus.sad_in;
            best_mv_x <= bus.mv_x_in;
            best_mv_y <= bus.mv_y_in;
          end
          if (bus.ctrl_done) begin
            err_r <= 1'b0;
          end else if (to_last) begin
            err_r <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_NEXT: begin
          // the final macroblock leaves the coordinates where they are
          if (!(x_last && y_last)) begin
            if (x_last) begin
              mb_x <= '0;
              mb_y <= mb_y + MB_BITS'(1);
            end else begin
              mb_x <= mb_x + MB_BITS'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ctrl_r   = r_lat;
  assign bus.res_sad  = best_sad;
  assign bus.res_mv_x = best_mv_x;
  assign bus.res_mv_y = best_mv_y;
  assign bus.res_mb_x = mb_x;
  assign bus.res_mb_y = mb_y;
  assign bus.res_err  = err_r;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Scoreboard bench for me_frame_scheduler: directed frames push expected
// results, a negedge monitor pops and compares on every result handshake.
module tb_me_frame_scheduler;
  localparam int MB_BITS = 7;
  localparam int SAD_W   = 16;
  localparam int TIMEOUT = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               frame_start;
  logic [MB_BITS-1:0] frame_w_mb;
  logic [MB_BITS-1:0] frame_h_mb;
  logic [1:0]         r_cfg;
  logic [MB_BITS-1:0] mb_x;
  logic [MB_BITS-1:0] mb_y;
  logic               busy;
  logic               frame_done;

  always #5 clk = ~clk;

  me_frame_scheduler_if #(.MB_BITS(MB_BITS), .SAD_W(SAD_W)) bus ();

  me_frame_scheduler #(.MB_BITS(MB_BITS), .SAD_W(SAD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .frame_w_mb  (frame_w_mb),
    .frame_h_mb  (frame_h_mb),
    .r_cfg       (r_cfg),
    .mb_x        (mb_x),
    .mb_y        (mb_y),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  typedef struct packed {
    logic [15:0] sad;
    logic [7:0]  mvx;
    logic [7:0]  mvy;
    logic [6:0]  mbx;
    logic [6:0]  mby;
    logic        err;
  } res_t;

  typedef struct packed {
    logic [15:0] sad;
    logic [7:0]  x;
    logic [7:0]  y;
  } cand_t;

  res_t  exp_q[$];
  cand_t cq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    go_cnt  = 0;
  int    fd_cnt  = 0;
  int    rv_cnt  = 0;
  logic [1:0] exp_r = 2'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input int sad, input int mvx, input int mvy,
                          input int mbx, input int mby, input int err);
    res_t e;
    e.sad = 16'(sad);
    e.mvx = 8'(mvx);
    e.mvy = 8'(mvy);
    e.mbx = 7'(mbx);
    e.mby = 7'(mby);
    e.err = 1'(err);
    exp_q.push_back(e);
  endtask

  task automatic push_cand(input int sad, input int x, input int y);
    cand_t c;
    c.sad = 16'(sad);
    c.x   = 8'(x);
    c.y   = 8'(y);
    cq.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int h, input logic [1:0] r);
    tick();
    frame_start = 1'b1;
    frame_w_mb  = 7'(w);
    frame_h_mb  = 7'(h);
    r_cfg       = r;
    exp_r       = r;
    tick();
    frame_start = 1'b0;
    r_cfg       = 2'd0;
  endtask

  task automatic wait_go(output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.ctrl_go) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_go: got no ctrl_go expected pulse within 200 cycles");
  endtask

  task automatic run_mb(input bit done_with_last, input bit give_done, output int lat);
    cand_t c;
    wait_go(lat);
    while (cq.size() > 0) begin
      c = cq.pop_front();
      tick();
      bus.sad_valid = 1'b1;
      bus.sad_in    = c.sad;
      bus.mv_x_in   = c.x;
      bus.mv_y_in   = c.y;
      if (cq.size() == 0 && done_with_last && give_done) bus.ctrl_done = 1'b1;
    end
    tick();
    bus.sad_valid = 1'b0;
    bus.ctrl_done = 1'b0;
    if (give_done && !done_with_last) begin
      bus.ctrl_done = 1'b1;
      tick();
      bus.ctrl_done = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain: got %0d pending results busy=%0d expected 0 and idle", exp_q.size(), busy);
  endtask

  // result monitor / scoreboard
  initial begin : monitor
    res_t got;
    res_t held;
    res_t e;
    bit   stall;
    bit   armed;
    int   hs_cnt;
    stall  = 1'b0;
    armed  = 1'b0;
    hs_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 1'b0;
        armed = 1'b0;
        continue;
      end
      got.sad = bus.res_sad;
      got.mvx = bus.res_mv_x;
      got.mvy = bus.res_mv_y;
      got.mbx = bus.res_mb_x;
      got.mby = bus.res_mb_y;
      got.err = bus.res_err;
      if (bus.ctrl_go) go_cnt++;
      if (bus.res_valid) rv_cnt++;
      if (busy) check("ctrl_r", 64'(bus.ctrl_r), 64'(exp_r));
      if (armed) begin
        hs_cnt++;
        if (bus.ctrl_go) begin
          check("handshake_to_go", 64'(hs_cnt), 64'd2);
          armed = 1'b0;
        end
      end
      if (frame_done) begin
        fd_cnt++;
        armed = 1'b0;
      end
      if (stall) begin
        check("valid_hold", 64'(bus.res_valid), 64'd1);
        if (bus.res_valid) check("res_hold", 64'(got), 64'(held));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL result: got unexpected %0h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(got), 64'(e));
        end
        stall  = 1'b0;
        armed  = 1'b1;
        hs_cnt = 0;
      end else if (bus.res_valid) begin
        stall = 1'b1;
        held  = got;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int cnt;
    int fd0;
    int go0;
    int rv0;
    frame_start   = 1'b0;
    frame_w_mb    = '0;
    frame_h_mb    = '0;
    r_cfg         = 2'd0;
    bus.ctrl_done = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in    = '0;
    bus.mv_x_in   = '0;
    bus.mv_y_in   = '0;
    bus.res_ready = 1'b1;

    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy",       64'(busy),          64'd0);
    check("rst_ctrl_go",    64'(bus.ctrl_go),   64'd0);
    check("rst_res_valid",  64'(bus.res_valid), 64'd0);
    check("rst_frame_done", 64'(frame_done),    64'd0);
    check("rst_res_sad",    64'(bus.res_sad),   64'hFFFF);
    check("rst_res_mv",     64'({bus.res_mv_x, bus.res_mv_y}), 64'd0);
    check("rst_mb",         64'({mb_x, mb_y, bus.res_mb_x, bus.res_mb_y}), 64'd0);
    check("rst_ctrl_r",     64'(bus.ctrl_r),    64'd0);
    check("rst_res_err",    64'(bus.res_err),   64'd0);
    reset = 1'b1;

    // two-MB frame, ties keep the earlier candidate
    fd0 = fd_cnt; go0 = go_cnt;
    start_frame(2, 1, 2'd1);
    push_exp(120, 8'h02, 8'hFD, 0, 0, 0);
    push_cand(300, 1, 1); push_cand(120, 8'h02, 8'hFD);
    push_cand(120, 5, 5); push_cand(500, 7, 7);
    run_mb(1'b0, 1'b1, lat);
    check("start_to_go", 64'(lat), 64'd1);
    push_exp(120, 8'h10, 8'h20, 1, 0, 0);
    push_cand(300, 3, 3); push_cand(120, 8'h10, 8'h20);
    push_cand(120, 8'h11, 8'h21); push_cand(500, 0, 0);
    run_mb(1'b0, 1'b1, lat);
    drain();
    check("f1_frame_done", 64'(fd_cnt - fd0), 64'd1);
    check("f1_ctrl_go",    64'(go_cnt - go0), 64'd2);

    // candidate arriving together with ctrl_done counts
    start_frame(1, 1, 2'd2);
    push_exp(5, 5, 6, 0, 0, 0);
    push_cand(12, 3, 3); push_cand(9, 1, 2); push_cand(5, 5, 6);
    run_mb(1'b1, 1'b1, lat);
    drain();

    // back-pressure: result held, candidates and done ignored in EMIT
    start_frame(2, 1, 2'd3);
    push_exp(50, 4, 4, 0, 0, 0);
    push_cand(50, 4, 4);
    bus.res_ready = 1'b0;
    run_mb(1'b0, 1'b1, lat);
    @(negedge clk);
    check("emit_valid", 64'(bus.res_valid), 64'd1);
    go0 = go_cnt;
    tick();
    bus.sad_valid = 1'b1; bus.sad_in = 16'd1; bus.mv_x_in = 8'd9; bus.mv_y_in = 8'd9;
    bus.ctrl_done = 1'b1;
    repeat (9) tick();
    bus.sad_valid = 1'b0; bus.ctrl_done = 1'b0;
    check("stall_no_go", 64'(go_cnt - go0), 64'd0);
    bus.res_ready = 1'b1;
    push_exp(16'hFFFF, 0, 0, 1, 0, 0);
    run_mb(1'b0, 1'b1, lat);
    drain();

    // timeout on first MB, normal second MB
    start_frame(2, 1, 2'd0);
    push_exp(40, 1, 2, 0, 0, 1);
    wait_go(lat);
    cnt = 0;
    fork
      begin
        tick();
        bus.sad_valid = 1'b1; bus.sad_in = 16'd40; bus.mv_x_in = 8'd1; bus.mv_y_in = 8'd2;
        tick();
        bus.sad_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          cnt++;
          if (bus.res_valid) break;
        end
      end
    join
    check("timeout_len", 64'(cnt), 64'(TIMEOUT + 1));
    push_exp(7, 3, 3, 1, 0, 0);
    push_cand(7, 3, 3);
    run_mb(1'b1, 1'b1, lat);
    drain();

    // zero dimension frames: immediate frame_done only
    for (int k = 0; k < 2; k++) begin
      fd0 = fd_cnt; go0 = go_cnt; rv0 = rv_cnt;
      if (k == 0) start_frame(0, 3, 2'd2);
      else        start_frame(4, 0, 2'd1);
      repeat (6) @(negedge clk);
      check("zero_frame_done", 64'(fd_cnt - fd0), 64'd1);
      check("zero_ctrl_go",    64'(go_cnt - go0), 64'd0);
      check("zero_res_valid",  64'(rv_cnt - rv0), 64'd0);
      check("zero_idle",       64'(busy),         64'd0);
    end

    // raster scan 3x2, no candidates at all
    fd0 = fd_cnt; go0 = go_cnt;
    start_frame(3, 2, 2'd0);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 3; x++) begin
        push_exp(16'hFFFF, 0, 0, x, y, 0);
        run_mb(1'b0, 1'b1, lat);
      end
    end
    drain();
    check("scan_frame_done", 64'(fd_cnt - fd0), 64'd1);
    check("scan_ctrl_go",    64'(go_cnt - go0), 64'd6);
    check("scan_last_mb",    64'({mb_x, mb_y}), 64'({7'd2, 7'd1}));

    // frame_start while busy is ignored
    fd0 = fd_cnt;
    start_frame(1, 1, 2'd1);
    push_exp(8, 2, 2, 0, 0, 0);
    wait_go(lat);
    tick();
    frame_start = 1'b1; frame_w_mb = 7'd0; r_cfg = 2'd3;
    bus.sad_valid = 1'b1; bus.sad_in = 16'd8; bus.mv_x_in = 8'd2; bus.mv_y_in = 8'd2;
    bus.ctrl_done = 1'b1;
    tick();
    frame_start = 1'b0; bus.sad_valid = 1'b0; bus.ctrl_done = 1'b0; r_cfg = 2'd0;
    drain();
    repeat (3) @(negedge clk);
    check("busy_start_ignored", 64'(fd_cnt - fd0), 64'd1);

    // reset during WAIT of MB (1,0), then restart
    start_frame(2, 1, 2'd2);
    push_exp(33, 1, 1, 0, 0, 0);
    push_cand(33, 1, 1);
    run_mb(1'b0, 1'b1, lat);
    wait_go(lat);
    tick();
    bus.sad_valid = 1'b1; bus.sad_in = 16'd2; bus.mv_x_in = 8'd4; bus.mv_y_in = 8'd4;
    tick();
    bus.sad_valid = 1'b0;
    fd0 = fd_cnt;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy",  64'(busy),          64'd0);
    check("rst_mid_valid", 64'(bus.res_valid), 64'd0);
    check("rst_mid_sad",   64'(bus.res_sad),   64'hFFFF);
    check("rst_mid_mb",    64'({mb_x, mb_y}),  64'd0);
    exp_r = 2'd0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_fd", 64'(fd_cnt - fd0),  64'd0);
    start_frame(1, 1, 2'd0);
    push_exp(16'hFFFF, 0, 0, 0, 0, 0);
    run_mb(1'b0, 1'b1, lat);
    check("restart_go_lat", 64'(lat), 64'd1);
    drain();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
